secuenciador_de_instrucciones: RTL and testbench

Multi-cycle fetch/decode/execute sequencer that drives `Unidad_de_control`. It owns the program counter and fetches 9-bit instruction words from program memory over a req/ack handshake. It latches the opcode and operands, issues a one-cycle execute strobe to the control unit, and then updates the PC from the control unit's jump decision. It sits between program memory and `Unidad_de_control` and is the only source of that unit's opcode and operand inputs.

---
 rtl/secuenciador_de_instrucciones.sv | 193 +++++++++++++++++++
 tb/tb_secuenciador_de_instrucciones.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_de_instrucciones.sv
// -----------------------------------------------------------------------------
// secuenciador_de_instrucciones
//
// Multi-cycle fetch/decode/execute sequencer in front of Unidad_de_control.
// It owns the program counter and fetches 9-bit instruction words from
// program memory over a req/ack handshake. The fetched opcode and operands
// are latched and held for the control unit. A one-cycle execute strobe is
// then issued, and the PC advances by one or loads the jump target returned
// by the control unit.
//
// Parameters:
//   PC_WIDTH     program counter / fetch address width (6..16)
//   ACK_TIMEOUT  FETCH cycles without ack before a fault (2..255)
//
// Ports:
//   i_Timming         clock, rising edge
//   i_Rst             asynchronous active-low reset
//   i_Start           run level: sampled in IDLE (start) and UPDATE (continue)
//   o_Mem_req         instruction fetch request, high for the whole FETCH phase
//   o_Mem_addr        fetch address, a direct copy of the PC register
//   i_Mem_ack         fetch data valid, only looked at during FETCH
//   i_Mem_data        instruction word {opcode[8:6], operandos[5:0]}
//   o_Operation_code  latched opcode for the control unit
//   o_Operandos       latched operands for the control unit
//   o_Hab             one-cycle execute strobe (EXEC state)
//   i_Senal_de_salto  jump decision from the control unit, valid in EXEC
//   o_Pc              program counter
//   o_Fase            state code: IDLE=0 FETCH=1 DECODE=2 EXEC=3 UPDATE=4 FAULT=7
//   o_Busy            high in every state except IDLE and FAULT
//   o_Error           sticky fetch-timeout fault
//
// Optional feature (macro SECUENCIADOR_CONTADOR_INSTR_EN):
//   o_Instr_count     16-bit count of retired instructions, +1 per UPDATE cycle
// -----------------------------------------------------------------------------
module secuenciador_de_instrucciones #(
    parameter int unsigned PC_WIDTH    = 6,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                i_Timming,
    input  logic                i_Rst,
    input  logic                i_Start,
    output logic                o_Mem_req,
    output logic [PC_WIDTH-1:0] o_Mem_addr,
    input  logic                i_Mem_ack,
    input  logic [8:0]          i_Mem_data,
    output logic [2:0]          o_Operation_code,
    output logic [5:0]          o_Operandos,
    output logic                o_Hab,
    input  logic                i_Senal_de_salto,
    output logic [PC_WIDTH-1:0] o_Pc,
    output logic [2:0]          o_Fase,
    output logic                o_Busy,
    output logic                o_Error
`ifdef SECUENCIADOR_CONTADOR_INSTR_EN
    ,
    output logic [15:0]         o_Instr_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FAULT  = 3'd7
    } fase_e;

    // Wait-counter value seen in the last allowed FETCH cycle.
    localparam logic [7:0]          WAIT_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);

    fase_e               state_q;
    logic                req_q;
    logic                hab_q;
    logic                busy_q;
    logic                error_q;
    logic                salto_q;
    logic [7:0]          wait_q;
    logic [2:0]          opcode_q;
    logic [5:0]          operandos_q;
    logic [PC_WIDTH-1:0] pc_q;
`ifdef SECUENCIADOR_CONTADOR_INSTR_EN
    logic [15:0]         count_q;
`endif

    // Single-process FSM: every output is a register updated on the same
    // edge as the state, so outputs change exactly with o_Fase.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge i_Timming or negedge i_Rst) begin
        if (!i_Rst) begin
            // NOTE: the asynchronous reset clears every register, so req drops
            // as soon as i_Rst falls, without waiting for a clock edge.
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            hab_q       <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            salto_q     <= 1'b0;
            wait_q      <= 8'd0;
            opcode_q    <= 3'd0;
            operandos_q <= 6'd0;
            pc_q        <= '0;
`ifdef SECUENCIADOR_CONTADOR_INSTR_EN
            count_q     <= 16'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Start) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        wait_q  <= 8'd0;
                    end
                end

                ST_FETCH: begin
                    // Ack is tested first so an ack in the last allowed
                    // cycle beats the timeout.
                    if (i_Mem_ack) begin
                        opcode_q    <= i_Mem_data[8:6];
                        operandos_q <= i_Mem_data[5:0];
                        req_q       <= 1'b0;
                        state_q     <= ST_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_FAULT;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end

                ST_DECODE: begin
                    // Strobe is raised on the edge that enters EXEC.
                    hab_q   <= 1'b1;
                    state_q <= ST_EXEC;
                end

                ST_EXEC: begin
                    hab_q   <= 1'b0;
                    salto_q <= i_Senal_de_salto;
                    state_q <= ST_UPDATE;
                end

                ST_UPDATE: begin
                    if (salto_q) begin
                        pc_q <= PC_WIDTH'(operandos_q);
                    end else begin
                        pc_q <= pc_q + PC_ONE;
                    end
`ifdef SECUENCIADOR_CONTADOR_INSTR_EN
                    count_q <= count_q + 16'd1;
`endif
                    if (i_Start) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        wait_q  <= 8'd0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                // FAULT, and the unused codes 5 and 6, all park in FAULT.
                default: begin
                    state_q <= ST_FAULT;
                    req_q   <= 1'b0;
                    hab_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    error_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_Mem_req        = req_q;
    assign o_Mem_addr       = pc_q;
    assign o_Pc             = pc_q;
    assign o_Operation_code = opcode_q;
    assign o_Operandos      = operandos_q;
    assign o_Hab            = hab_q;
    assign o_Fase           = state_q;
    assign o_Busy           = busy_q;
    assign o_Error          = error_q;
`ifdef SECUENCIADOR_CONTADOR_INSTR_EN
    assign o_Instr_count    = count_q;
`endif

endmodule

// File: tb/tb_secuenciador_de_instrucciones.sv
// -----------------------------------------------------------------------------
// Self-checking bench for secuenciador_de_instrucciones.
// A small memory/control-unit model answers fetches. Each accepted fetch
// pushes the expected opcode, operands and next PC to a scoreboard queue,
// which is popped when the DUT raises its execute strobe.
// -----------------------------------------------------------------------------
module tb_secuenciador_de_instrucciones;

    localparam int PC_WIDTH    = 6;
    localparam int ACK_TIMEOUT = 15;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                ack;
    logic [8:0]          data;
    logic                salto;
    logic                mem_req;
    logic [PC_WIDTH-1:0] mem_addr;
    logic [2:0]          opcode;
    logic [5:0]          operandos;
    logic                hab;
    logic [PC_WIDTH-1:0] pc;
    logic [2:0]          fase;
    logic                busy;
    logic                error;
`ifdef SECUENCIADOR_CONTADOR_INSTR_EN
    logic [15:0]         instr_count;
`endif

    secuenciador_de_instrucciones #(
        .PC_WIDTH   (PC_WIDTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .i_Timming       (clk),
        .i_Rst           (rst_n),
        .i_Start         (start),
        .o_Mem_req       (mem_req),
        .o_Mem_addr      (mem_addr),
        .i_Mem_ack       (ack),
        .i_Mem_data      (data),
        .o_Operation_code(opcode),
        .o_Operandos     (operandos),
        .o_Hab           (hab),
        .i_Senal_de_salto(salto),
        .o_Pc            (pc),
        .o_Fase          (fase),
        .o_Busy          (busy),
        .o_Error         (error)
`ifdef SECUENCIADOR_CONTADOR_INSTR_EN
        ,
        .o_Instr_count   (instr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]          op;
        logic [5:0]          opd;
        logic [PC_WIDTH-1:0] next_pc;
    } exp_t;

    exp_t                sb_q[$];
    logic [PC_WIDTH-1:0] model_pc;
    int                  model_cnt;
    int                  n_vec = 0;
    int                  n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_count(input string tag);
`ifdef SECUENCIADOR_CONTADOR_INSTR_EN
        check(tag, 32'(instr_count), 32'(model_cnt));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},  32'(mem_req),   0);
        check({tag, "_addr"}, 32'(mem_addr),  0);
        check({tag, "_pc"},   32'(pc),        0);
        check({tag, "_op"},   32'(opcode),    0);
        check({tag, "_opd"},  32'(operandos), 0);
        check({tag, "_hab"},  32'(hab),       0);
        check({tag, "_fase"}, 32'(fase),      0);
        check({tag, "_busy"}, 32'(busy),      0);
        check({tag, "_err"},  32'(error),     0);
        check_count({tag, "_cnt"});
    endtask

    // One full instruction: waits for the request, answers after `delay`
    // ack-less FETCH cycles, then follows DECODE/EXEC/UPDATE.
    task automatic run_instr(input logic [8:0] word, input logic jmp,
                             input int delay, input logic next_start);
        exp_t e;
        int   budget = 20;
        while (!mem_req && budget > 0) begin
            tick();
            budget--;
        end
        check("req_seen", 32'(mem_req), 1);
        check("fetch_addr", 32'(mem_addr), 32'(model_pc));
        check("fetch_fase", 32'(fase), 1);
        for (int i = 0; i < delay; i++) tick();
        check("wait_fase", 32'(fase), 1);
        check("wait_err", 32'(error), 0);

        e.op      = word[8:6];
        e.opd     = word[5:0];
        e.next_pc = jmp ? PC_WIDTH'(word[5:0]) : PC_WIDTH'(model_pc + 1'b1);
        ack  = 1'b1;
        data = word;
        sb_q.push_back(e);
        tick();
        ack  = 1'b0;
        data = 9'($urandom);
        check("dec_fase", 32'(fase), 2);
        check("dec_req",  32'(mem_req), 0);
        check("dec_hab",  32'(hab), 0);

        tick();
        check("exec_fase", 32'(fase), 3);
        check("exec_hab",  32'(hab), 1);
        check("exec_busy", 32'(busy), 1);
        if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("exec_op",  32'(opcode),    32'(e.op));
            check("exec_opd", 32'(operandos), 32'(e.opd));
        end
        salto = jmp;

        tick();
        check("upd_fase", 32'(fase), 4);
        check("upd_hab",  32'(hab), 0);
        salto = 1'($urandom);
        start = next_start;

        tick();
        model_pc = e.next_pc;
        model_cnt++;
        check("new_pc",   32'(pc), 32'(model_pc));
        check("new_addr", 32'(mem_addr), 32'(model_pc));
        check("new_fase", 32'(fase), next_start ? 1 : 0);
        check("new_req",  32'(mem_req), 32'(next_start));
        check("new_busy", 32'(busy), 32'(next_start));
        check_count("new_cnt");
    endtask

    initial begin
        model_pc  = '0;
        model_cnt = 0;
        rst_n = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        salto = 1'b0;
        data  = 9'd0;
        #2;
        // Reset with random inputs and ack held high.
        rst_n = 1'b0;
        start = 1'($urandom);
        ack   = 1'b1;
        data  = 9'($urandom);
        salto = 1'($urandom);
        #1;
        check_all_zero("rst_async");
        repeat (3) begin
            tick();
            start = 1'($urandom);
            data  = 9'($urandom);
        end
        check_all_zero("rst_hold");

        // Release with start low: stays in IDLE.
        start = 1'b0;
        ack   = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_fase", 32'(fase), 0);
        check("idle_req",  32'(mem_req), 0);

        // Sequential fetch, ack in the first FETCH cycle.
        start = 1'b1;
        tick();
        run_instr(9'b000_111101, 1'b0, 0, 1'b1);
        // Jump taken, then the same word not taken.
        run_instr(9'b111_001110, 1'b1, 2, 1'b1);
        run_instr(9'b111_001110, 1'b0, 0, 1'b1);
        // Ack in the last allowed FETCH cycle.
        run_instr(9'b010_101010, 1'b0, ACK_TIMEOUT - 1, 1'b1);
        // Jump to 63, then wrap to 0 and stop.
        run_instr(9'b000_111111, 1'b1, 1, 1'b1);
        run_instr(9'b101_000011, 1'b0, 0, 1'b0);
        repeat (3) tick();
        check("stop_fase", 32'(fase), 0);
        check("stop_pc",   32'(pc), 0);
        check_count("stop_cnt");

        // Timeout: no ack at all.
        start = 1'b1;
        tick();
        check("to_fetch", 32'(fase), 1);
        for (int i = 0; i < ACK_TIMEOUT - 1; i++) tick();
        check("to_last_fetch", 32'(fase), 1);
        check("to_last_req",   32'(mem_req), 1);
        tick();
        check("fault_fase", 32'(fase), 7);
        check("fault_err",  32'(error), 1);
        check("fault_req",  32'(mem_req), 0);
        check("fault_busy", 32'(busy), 0);
        ack  = 1'b1;
        data = 9'($urandom);
        repeat (5) tick();
        check("fault_stay_fase", 32'(fase), 7);
        check("fault_stay_err",  32'(error), 1);
        check("fault_stay_hab",  32'(hab), 0);
        check("fault_stay_req",  32'(mem_req), 0);

        // Only reset leaves FAULT.
        rst_n = 1'b0;
        #1;
        check("fault_rst_fase", 32'(fase), 0);
        check("fault_rst_err",  32'(error), 0);
        ack = 1'b0;
        @(negedge clk);
        model_pc  = '0;
        model_cnt = 0;
        check_count("fault_rst_cnt");
        start = 1'b1;
        rst_n = 1'b1;
        tick();
        run_instr(9'b011_000101, 1'b0, 0, 1'b1);

        // Reset mid-fetch: request drops before the next clock edge.
        check("mid_req_before", 32'(mem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_req_drop", 32'(mem_req), 0);
        model_pc  = '0;
        model_cnt = 0;
        @(negedge clk);
        check_all_zero("mid_rst");
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("mid_idle", 32'(fase), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
